// File: rtl/lzc_index_decoder_if.sv
// Handshake bundle between the LZC encoder side and the index decoder.
// Producer drives the in_* request and out_ready; the decoder drives the rest.
// Optional parity signals appear only when LZC_DEC_PARITY_EN is defined.
interface lzc_index_decoder_if #(
  parameter int unsigned W  = 32,
  parameter int unsigned IW = $clog2(W)
);
  logic          in_valid;
  logic          in_ready;
  logic [IW-1:0] in_index;
  logic          in_zero;
  logic          in_therm;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_word;
  logic          out_zero;
  logic          busy;
`ifdef LZC_DEC_PARITY_EN
  logic          in_par;
  logic          out_par;
  logic          out_err;

  modport master (
    output in_valid, in_index, in_zero, in_therm, in_par, out_ready,
    input  in_ready, out_valid, out_word, out_zero, busy, out_par, out_err
  );

  modport slave (
    input  in_valid, in_index, in_zero, in_therm, in_par, out_ready,
    output in_ready, out_valid, out_word, out_zero, busy, out_par, out_err
  );
`else
  modport master (
    output in_valid, in_index, in_zero, in_therm, out_ready,
    input  in_ready, out_valid, out_word, out_zero, busy
  );

  modport slave (
    input  in_valid, in_index, in_zero, in_therm, out_ready,
    output in_ready, out_valid, out_word, out_zero, busy
  );
`endif
endinterface

// File: rtl/lzc_index_decoder.sv
// lzc_index_decoder: rebuilds a one-hot or thermometer word from a
// first-set-bit index (bit 0 = highest priority), behind a 2-entry skid FIFO.
// Optional macro LZC_DEC_PARITY_EN adds per-entry parity and parity-error.
module lzc_index_decoder #(
  parameter  int unsigned W  = 32,
  localparam int unsigned IW = $clog2(W)
) (
  input logic                  clk,
  input logic                  rst,
  lzc_index_decoder_if.slave   bus
);

  localparam int unsigned DEPTH = 2;

  typedef struct packed {
    logic [W-1:0] word;
    logic         zero;
`ifdef LZC_DEC_PARITY_EN
    logic         par;
    logic         err;
`endif
  } entry_t;

  // Occupancy doubles as the FIFO count.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_nxt;
  entry_t r_mem [DEPTH];
  logic   r_head;
  logic   r_tail;
  logic   r_in_ready;
  logic   r_out_valid;
  logic   r_busy;
  entry_t w_dec;
  logic   w_push;
  logic   w_pop;

  assign w_push = bus.in_valid & r_in_ready;
  assign w_pop  = r_out_valid & bus.out_ready;

  // Decode the incoming index into the entry that will be stored.
  always_comb begin
    w_dec = '0;
    for (int k = 0; k < int'(W); k++) begin
      if (!bus.in_zero) begin
        if (bus.in_therm) w_dec.word[k] = (IW'(k) >= bus.in_index);
        else              w_dec.word[k] = (IW'(k) == bus.in_index);
      end
    end
    w_dec.zero = bus.in_zero;
`ifdef LZC_DEC_PARITY_EN
    w_dec.par = ^w_dec.word;
    w_dec.err = w_dec.par ^ bus.in_par;
`endif
  end

  // Next occupancy from push/pop; FULL never accepts so push is 0 there.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      EMPTY: if (w_push) w_state_nxt = ONE;
      ONE: begin
        if (w_push && !w_pop)      w_state_nxt = FULL;
        else if (w_pop && !w_push) w_state_nxt = EMPTY;
      end
      FULL:    if (w_pop) w_state_nxt = ONE;
      default: w_state_nxt = EMPTY;
    endcase
  end

  // State, pointers, storage and registered status flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= EMPTY;
      r_head      <= 1'b0;
      r_tail      <= 1'b0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
      for (int unsigned i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_in_ready  <= (w_state_nxt != FULL);
      r_out_valid <= (w_state_nxt != EMPTY);
      r_busy      <= (w_state_nxt != EMPTY);
      if (w_push) begin
        r_mem[r_tail] <= w_dec;
        r_tail        <= ~r_tail;
      end
      if (w_pop) r_head <= ~r_head;
    end
  end

  assign bus.in_ready  = r_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.busy      = r_busy;
  assign bus.out_word  = r_mem[r_head].word;
  assign bus.out_zero  = r_mem[r_head].zero;
`ifdef LZC_DEC_PARITY_EN
  assign bus.out_par   = r_mem[r_head].par;
  assign bus.out_err   = r_mem[r_head].err;
`endif

endmodule

// File: tb/tb_lzc_index_decoder.sv
// Directed self-checking bench for lzc_index_decoder (W=32).
module tb_lzc_index_decoder;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_pass   = 0;

  always #5 clk = ~clk;

  lzc_index_decoder_if #(.W(32)) bus ();

  lzc_index_decoder #(.W(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic drive(input logic v, input int idx, input logic therm, input logic zero);
    bus.in_valid = v;
    bus.in_index = 5'(idx);
    bus.in_therm = therm;
    bus.in_zero  = zero;
  endtask

  // Push one request into an empty decoder and check the word one cycle later.
  task automatic single(input string tag, input int idx, input logic therm,
                        input logic zero, input logic [31:0] exp_word);
    @(negedge clk);
    bus.out_ready = 1'b1;
    drive(1'b1, idx, therm, zero);
    @(negedge clk);
    drive(1'b0, 0, 1'b0, 1'b0);
    check({tag, "_valid"}, 64'(bus.out_valid), 64'd1);
    check({tag, "_word"},  64'(bus.out_word),  64'(exp_word));
    check({tag, "_zero"},  64'(bus.out_zero),  64'(zero));
  endtask

  logic [31:0] exp_q [$];
  logic [31:0] exp_w;

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_index  = '0;
    bus.in_zero   = 1'b0;
    bus.in_therm  = 1'b0;
    bus.out_ready = 1'b0;
`ifdef LZC_DEC_PARITY_EN
    bus.in_par    = 1'b0;
`endif
    repeat (2) @(negedge clk);
    check("rst_valid", 64'(bus.out_valid), 64'd0);
    check("rst_busy",  64'(bus.busy),      64'd0);
    check("rst_ready", 64'(bus.in_ready),  64'd1);
    check("rst_word",  64'(bus.out_word),  64'd0);
    check("rst_zero",  64'(bus.out_zero),  64'd0);
    rst = 1'b0;

    // One-hot sweep at full throughput.
    bus.out_ready = 1'b1;
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      if (i > 0) begin
        exp_w = 32'h1 << (i - 1);
        check("oh_valid", 64'(bus.out_valid), 64'd1);
        check("oh_word",  64'(bus.out_word),  64'(exp_w));
      end
      check("oh_ready", 64'(bus.in_ready), 64'd1);
      drive(1'b1, i, 1'b0, 1'b0);
    end
    @(negedge clk);
    drive(1'b0, 0, 1'b0, 1'b0);
    check("oh_word31", 64'(bus.out_word), 64'h8000_0000);
    @(negedge clk);
    check("oh_drained", 64'(bus.out_valid), 64'd0);

    // Thermometer and zero-flag cases.
    single("th0",   0,  1'b1, 1'b0, 32'hFFFF_FFFF);
    single("th31",  31, 1'b1, 1'b0, 32'h8000_0000);
    single("th4",   4,  1'b1, 1'b0, 32'hFFFF_FFF0);
    single("thz7",  7,  1'b1, 1'b1, 32'h0000_0000);
    single("ohz9",  9,  1'b0, 1'b1, 32'h0000_0000);
    @(negedge clk);

    // Backpressure: fill, stall a third request, then release.
    bus.out_ready = 1'b0;
    drive(1'b1, 1, 1'b0, 1'b0);
    @(negedge clk);
    check("bp_w1",   64'(bus.out_word),  64'h2);
    check("bp_rdy1", 64'(bus.in_ready),  64'd1);
    drive(1'b1, 2, 1'b0, 1'b0);
    @(negedge clk);
    check("bp_rdy2", 64'(bus.in_ready),  64'd0);
    check("bp_busy", 64'(bus.busy),      64'd1);
    drive(1'b1, 3, 1'b0, 1'b0);
    repeat (2) begin
      @(negedge clk);
      check("bp_stall_rdy",  64'(bus.in_ready),  64'd0);
      check("bp_stall_word", 64'(bus.out_word),  64'h2);
      check("bp_stall_vld",  64'(bus.out_valid), 64'd1);
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    check("bp_w2",   64'(bus.out_word), 64'h4);
    check("bp_rdy3", 64'(bus.in_ready), 64'd1);
    @(negedge clk);
    drive(1'b0, 0, 1'b0, 1'b0);
    check("bp_w3",   64'(bus.out_word),  64'h8);
    check("bp_vld3", 64'(bus.out_valid), 64'd1);
    @(negedge clk);
    check("bp_empty", 64'(bus.out_valid), 64'd0);
    check("bp_idle",  64'(bus.busy),      64'd0);

    // Steady push+pop with random requests against a scoreboard.
    for (int i = 0; i < 21; i++) begin
      int   idx;
      logic th;
      logic z;
      @(negedge clk);
      if (i > 0) begin
        exp_w = exp_q.pop_front();
        check("pp_word", 64'(bus.out_word), 64'(exp_w));
        check("pp_busy", 64'(bus.busy),     64'd1);
        check("pp_rdy",  64'(bus.in_ready), 64'd1);
      end
      if (i < 20) begin
        idx = int'($urandom_range(31, 0));
        th  = 1'($urandom_range(1, 0));
        z   = ($urandom_range(7, 0) == 0);
        drive(1'b1, idx, th, z);
        if (z)       exp_q.push_back(32'h0);
        else if (th) exp_q.push_back(32'hFFFF_FFFF << idx);
        else         exp_q.push_back(32'h1 << idx);
      end else begin
        drive(1'b0, 0, 1'b0, 1'b0);
      end
    end
    @(negedge clk);
    check("pp_empty", 64'(bus.out_valid), 64'd0);

    // Asynchronous reset while FULL.
    bus.out_ready = 1'b0;
    drive(1'b1, 10, 1'b0, 1'b0);
    @(negedge clk);
    drive(1'b1, 11, 1'b0, 1'b0);
    @(negedge clk);
    check("ar_full", 64'(bus.in_ready), 64'd0);
    drive(1'b0, 0, 1'b0, 1'b0);
    #2 rst = 1'b1;
    #1;
    check("ar_valid", 64'(bus.out_valid), 64'd0);
    check("ar_busy",  64'(bus.busy),      64'd0);
    check("ar_ready", 64'(bus.in_ready),  64'd1);
    @(negedge clk);
    rst = 1'b0;
    single("ar_push3", 3, 1'b0, 1'b0, 32'h0000_0008);
    @(negedge clk);

`ifdef LZC_DEC_PARITY_EN
    bus.in_par = 1'b1;
    single("par_oh5", 5, 1'b0, 1'b0, 32'h0000_0020);
    check("par_oh5_par", 64'(bus.out_par), 64'd1);
    check("par_oh5_err", 64'(bus.out_err), 64'd0);
    single("par_th0", 0, 1'b1, 1'b0, 32'hFFFF_FFFF);
    check("par_th0_par", 64'(bus.out_par), 64'd0);
    check("par_th0_err", 64'(bus.out_err), 64'd1);
    bus.in_par = 1'b0;
    @(negedge clk);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/lzc_index_decoder.md
Name: lzc_index_decoder

Overview:
- Inverse of the 32-bit leading-zero/priority encoder logic. It accepts an encoded first-set-bit index plus an all-zero flag and rebuilds the 32-bit word: a one-hot word or a thermometer mask.
- Bit 0 is the highest-priority (first-scanned) position, matching the encoder's scan order.
- Sits downstream of the encoder in the normalise/mask datapath, behind a valid/ready handshake, with a 2-entry output buffer.

Parameters:
- W, 32, decoded word width; power of two, 2..64.
- IW, $clog2(W), index width.
- DEPTH, 2, output buffer entries; fixed at 2 (skid pair).

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous reset, active-high.
- in_valid  in  1  request valid.
- in_ready  out  1  decoder can accept this cycle.
- in_index  in  IW  first-set-bit position, 0 = highest priority.
- in_zero  in  1  encoder saw an all-zero word; in_index is ignored.
- in_therm  in  1  0 = one-hot output, 1 = thermometer output.
- out_valid  out  1  out_word valid.
- out_ready  in  1  consumer accepts.
- out_word  out  W  decoded word.
- out_zero  out  1  in_zero of this entry, passed through.
- busy  out  1  at least one entry is buffered.

Behaviour:
- Reset (async assert; release synchronous to clk):
  - buffer empty: out_valid=0, busy=0, in_ready=1;
  - out_word=0, out_zero=0;
  - a held request is dropped when reset asserts mid-transfer.
- Transfer rules:
  - input transfer when in_valid & in_ready;
  - output transfer when out_valid & out_ready.
- Decode (combinational on the accepted input, registered into the buffer):
  - in_zero=1: word = all zeros, for both modes.
  - one-hot: word[in_index]=1, all other bits 0.
  - thermometer: word[k]=1 for every k >= in_index, 0 for k < in_index. Index 0 gives all ones; index W-1 gives only bit W-1.
  - in_index >= W: impossible when W=2^IW, so no range check.
- Latency: input accepted on cycle N appears on out_word with out_valid=1 on cycle N+1 (registered, 1 cycle). No combinational path from in_* to out_*.
- Buffer: 2-entry FIFO with head and tail pointers and a 2-bit count.
  - States EMPTY(0), ONE(1), FULL(2).
  - EMPTY: in accept -> ONE.
  - ONE: in accept & no out transfer -> FULL; out transfer & no in accept -> EMPTY; both -> ONE (new entry replaces popped one, order kept).
  - FULL: out transfer -> ONE; no input is accepted.
- Ready and status:
  - in_ready = (count != 2); registered, no dependence on out_ready. Full throughput when the consumer is always ready.
  - busy = (count != 0).
  - out_valid = (count != 0); out_word and out_zero always come from the head entry.
- Outputs hold stable while out_valid=1 & out_ready=0.
- Ordering is strict FIFO; no entry is ever dropped or duplicated.
- Pointer wrap: a 1-bit pointer toggles each push/pop.

Optional Feature:
- Macro: LZC_DEC_PARITY_EN.
- When defined:
  - adds port out_par (out, 1) = even parity (XOR) of out_word, stored per entry and reset to 0;
  - adds port in_par (in, 1) = parity expected by the encoder side.
  - Each entry stores err = (computed parity != in_par). Exposed on port out_err (out, 1), valid with out_valid, reset 0.
- When undefined: no out_par, in_par or out_err ports; no extra storage; behaviour otherwise identical.

Test Plan:
- Reset mid-stream: fill to FULL, assert rst asynchronously between edges -> out_valid=0, busy=0, in_ready=1 immediately; first post-reset push index 3 one-hot -> out_word=0x00000008 one cycle later.
- One-hot sweep: push index 0..31 with out_ready=1 -> out_word=1<<i each cycle, one output per cycle, in_ready stays 1.
- Thermometer: index 0 -> 0xFFFFFFFF; index 31 -> 0x80000000; index 4 -> 0xFFFFFFF0; in_zero=1 with index 7 -> 0x00000000, out_zero=1.
- Backpressure: out_ready=0, push indices 1, 2 -> in_ready=0 after the second; third request stalls. Release out_ready -> 0x2 then 0x4 then the third, in order; out_word is stable while stalled.
- Simultaneous push/pop in ONE state over 20 random cycles -> count stays 1; output sequence equals input sequence (scoreboard).
- LZC_DEC_PARITY_EN: one-hot index 5, in_par=1 -> out_par=1, out_err=0; thermometer index 0, in_par=1 -> out_par=0, out_err=1.
